peaks_host_reader: RTL and testbench

//  Drains per-frame peak lists from the peaks stage for the HPS/host over an Avalon-MM read-only slave.

---
 rtl/peaks_host_reader_if.sv | 15 +
 rtl/peaks_host_reader.sv | 94 +++++++++
 tb/tb_peaks_host_reader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/peaks_host_reader_if.sv
// peaks_host_reader_if: Avalon-MM read-only slave bus between the host bridge and peaks_host_reader
//   chipselect  host -> slave  slave select
//   read        host -> slave  read strobe, effective only with chipselect
//   address     host -> slave  4-bit word address
//   readdata    slave -> host  registered read data, valid the cycle after read
//   irq         slave -> host  high while frames are pending
interface peaks_host_reader_if;
    logic        chipselect;
    logic        read;
    logic [3:0]  address;
    logic [31:0] readdata;
    logic        irq;
    modport master (output chipselect, read, address, input readdata, irq);
    modport slave (input chipselect, read, address, output readdata, irq);
endinterface

// File: rtl/peaks_host_reader.sv
// peaks_host_reader: buffers per-frame peak lists in a DEPTH-frame FIFO for host readout over Avalon-MM
//   CLOCK_50       clock, rising edge
//   reset          synchronous active-high reset
//   peaks_valid_i  1-cycle strobe marking a complete frame on amplitudes_i/freqs_i
//   amplitudes_i   PEAKS amplitudes, index 0 is peak 0
//   freqs_i        PEAKS frequency bins, index 0 is peak 0
//   bus            Avalon slave: status at 0, head peaks at 1..PEAKS, pop at PEAKS+1
module peaks_host_reader #(
    parameter int PEAKS      = 6,
    parameter int FREQ_WIDTH = 8,
    parameter int AMPL_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                                CLOCK_50,
    input  logic                                reset,
    input  logic                                peaks_valid_i,
    input  logic [PEAKS-1:0][AMPL_WIDTH-1:0]    amplitudes_i,
    input  logic [PEAKS-1:0][FREQ_WIDTH-1:0]    freqs_i,
    peaks_host_reader_if.slave                  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int KW = PEAKS > 1 ? $clog2(PEAKS) : 1;
    localparam logic [3:0] POP_ADDR = 4'(PEAKS + 1);

    logic [PEAKS-1:0][AMPL_WIDTH-1:0] amp_mem [DEPTH];
    logic [PEAKS-1:0][FREQ_WIDTH-1:0] freq_mem [DEPTH];
    logic [15:0]                      id_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   frame_id_q;
    logic          overflow_q, overflow_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          irq_q;

    logic          rd, empty, full, pop, push, stat_rd, is_peak;
    logic [KW-1:0] k;
    logic [31:0]   status, peak_word;

    assign rd      = bus.chipselect & bus.read;
    assign empty   = count_q == '0;
    assign full    = count_q == CW'(DEPTH);
    assign stat_rd = rd && bus.address == 4'd0;
    assign is_peak = bus.address != 4'd0 && bus.address <= 4'(PEAKS);
    assign pop     = rd && bus.address == POP_ADDR && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    assign push    = peaks_valid_i && (!full || pop);
    assign k       = KW'(bus.address - 4'd1);

    assign status    = {overflow_q, 7'd0, 8'(DEPTH), 8'(count_q), 7'd0, empty};
    assign peak_word = (32'(amp_mem[rd_ptr_q][k]) << 16) | 32'(freq_mem[rd_ptr_q][k]);

    always_comb begin
        readdata_d = !rd     ? readdata_q :
                     stat_rd ? status :
                     is_peak ? (empty ? 32'd0 : peak_word) :
                     pop     ? {16'd0, id_mem[rd_ptr_q]} : 32'd0;
        // A drop in the same cycle as a status read keeps the flag set.
        overflow_d = (peaks_valid_i && !push) || (overflow_q && !stat_rd);
        count_d    = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            frame_id_q <= '0;
            overflow_q <= 1'b0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + PW'(push);
            rd_ptr_q   <= rd_ptr_q + PW'(pop);
            count_q    <= count_d;
            frame_id_q <= frame_id_q + 16'(peaks_valid_i);
            overflow_q <= overflow_d;
            readdata_q <= readdata_d;
            irq_q      <= count_q != '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset && push) begin
            amp_mem[wr_ptr_q]  <= amplitudes_i;
            freq_mem[wr_ptr_q] <= freqs_i;
            id_mem[wr_ptr_q]   <= frame_id_q;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_peaks_host_reader.sv
// tb_peaks_host_reader: directed self-checking bench for peaks_host_reader
module tb_peaks_host_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic peaks_valid = 1'b0;
    logic [5:0][15:0] amps = '0;
    logic [5:0][7:0]  freqs = '0;
    logic [31:0] d;
    int checks = 0;
    int fails = 0;

    peaks_host_reader_if bus ();

    peaks_host_reader dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .peaks_valid_i (peaks_valid),
        .amplitudes_i  (amps),
        .freqs_i       (freqs),
        .bus           (bus)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_frame(input int base);
        for (int i = 0; i < 6; i++) begin
            amps[i]  = 16'(100 + base + i);
            freqs[i] = 8'(base + i);
        end
    endtask

    task automatic push();
        @(negedge clk);
        peaks_valid = 1'b1;
        @(negedge clk);
        peaks_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read = 1'b1;
        bus.address = a;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read = 1'b0;
        v = bus.readdata;
    endtask

    task automatic rd_push(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        peaks_valid = 1'b1;
        bus.chipselect = 1'b1;
        bus.read = 1'b1;
        bus.address = a;
        @(negedge clk);
        peaks_valid = 1'b0;
        bus.chipselect = 1'b0;
        bus.read = 1'b0;
        v = bus.readdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.chipselect = 1'b0;
        bus.read = 1'b0;
        bus.address = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_irq", 32'(bus.irq), 32'h0);
        rd(4'd0, d); check("reset_status", d, 32'h00040001);

        amps  = {16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        freqs = {8'd40, 8'd33, 8'd20, 8'd12, 8'd10, 8'd3};
        push();
        rd(4'd1, d); check("peak1", d, 32'h00090003);
        @(negedge clk); check("readdata_hold", bus.readdata, 32'h00090003);
        rd(4'd6, d); check("peak6", d, 32'h00040028);
        check("irq_pending", 32'(bus.irq), 32'h1);
        rd(4'd7, d); check("pop_id0", d, 32'h0);
        rd(4'd0, d); check("status_empty", d, 32'h00040001);
        check("irq_clear", 32'(bus.irq), 32'h0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_frame(i);
            push();
        end
        rd(4'd1, d); check("full_head_peak", d, {16'd100, 16'd0});
        rd(4'd0, d); check("status_overflow", d, 32'h80040400);
        rd(4'd0, d); check("status_ovf_cleared", d, 32'h00040400);
        for (int i = 0; i < 4; i++) begin
            rd(4'd7, d); check($sformatf("pop_id%0d", i), d, 32'(i));
        end
        rd(4'd7, d); check("pop_empty", d, 32'h0);
        rd(4'd1, d); check("peak_empty", d, 32'h0);

        do_reset();
        for (int i = 0; i < 4; i++) push();
        rd_push(4'd7, d); check("full_pop_push", d, 32'h0);
        rd(4'd0, d); check("full_stays_full", d, 32'h00040400);
        for (int i = 1; i < 5; i++) begin
            rd(4'd7, d); check($sformatf("drain_id%0d", i), d, 32'(i));
        end
        rd(4'd7, d); check("pop_empty2", d, 32'h0);
        rd(4'd8, d); check("addr8", d, 32'h0);
        rd(4'd9, d); check("addr9", d, 32'h0);
        rd(4'd15, d); check("addr15", d, 32'h0);
        rd(4'd0, d); check("status_after_empty_pops", d, 32'h00040001);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_frame(3 * i);
            push();
            rd(4'd1, d); check($sformatf("wrap_peak%0d", i), d, {16'(100 + 3 * i), 16'(3 * i)});
            rd(4'd7, d); check($sformatf("wrap_id%0d", i), d, 32'(i));
        end
        rd(4'd0, d); check("status_after_wrap", d, 32'h00040001);

        for (int i = 0; i < 3; i++) push();
        rd(4'd0, d); check("status_count3", d, 32'h00040300);
        @(negedge clk);
        reset = 1'b1;
        peaks_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        peaks_valid = 1'b0;
        rd(4'd0, d); check("status_mid_reset", d, 32'h00040001);
        check("irq_mid_reset", 32'(bus.irq), 32'h0);
        push();
        rd(4'd7, d); check("id_after_reset", d, 32'h0);

        rd_push(4'd7, d); check("empty_pop_push", d, 32'h0);
        rd(4'd0, d); check("status_count1", d, 32'h00040100);
        rd(4'd7, d); check("pop_id1", d, 32'h1);

        do_reset();
        for (int i = 0; i < 4; i++) push();
        rd_push(4'd0, d); check("status_with_drop", d, 32'h00040400);
        rd(4'd0, d); check("overflow_set_wins", d, 32'h80040400);
        rd(4'd0, d); check("overflow_cleared", d, 32'h00040400);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
